decode_regfile: RTL and testbench
=================================

DECODE_REGFILE -- requirements
Module: decode_regfile

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width; legal values are 16 or greater.
REQ-002 Parameter NREG, default 8, number of registers; legal values are 8 or fewer, since the register index is the 3-bit ISA field.
REQ-003 Parameter R0_ZERO, default 1; when 1, r0 reads as zero and writes to it are discarded.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  instruction handshake.
REQ-007 instr  in  16  instruction word.
REQ-008 wb_en / wb_addr / wb_data  in  1 / 3 / DATA_W  write-back port.
REQ-009 flush  in  1  discards the held output instruction.
REQ-010 out_valid / out_ready  out / in  1 / 1  decoded-output handshake.
REQ-011 alu1, alu2  out  DATA_W  ALU operands.
REQ-012 opcode  out  4  carries instr[7:4].
REQ-013 writereg  out  1  destination register is written.
REQ-014 memwrite  out  2  00 = none, 01 = load, 10 = store.
REQ-015 regaddress  out  3  destination register index.
REQ-016 address / storedata  out  DATA_W / DATA_W  memory address and store data.

Function
REQ-017 Decode by class instr[15:14]. rs = instr[13:11], rt = instr[10:8], imm8 = sign-extended instr[7:0].
REQ-018 Class 3 (ALU):
- alu1 = R[rs].
- alu2 = R[rt] when instr[7:4] <= 8; otherwise zero-extended instr[3:0].
- writereg = 1, memwrite = 00, regaddress = rt.
REQ-019 Class 0 (load):
- alu1 = R[rs], alu2 = R[rt].
- address = R[rt] + imm8, modulo 2^DATA_W.
- writereg = 1, memwrite = 01, regaddress = rs.
REQ-020 Class 1 (store):
- storedata = R[rs], address = R[rt] + imm8.
- writereg = 0, memwrite = 10.
REQ-021 Class 2 (load immediate):
- address = imm8.
- writereg = 1, memwrite = 01, regaddress = rt.
- alu1 = alu2 = 0.
REQ-022 Outputs not named for a class are driven to zero.
REQ-023 in_ready = !out_valid || out_ready. This is combinational, with no dependence on in_valid.
REQ-024 Capture occurs on in_valid && in_ready. The outputs update at that edge and out_valid = 1 (one-cycle latency).
REQ-025 When out_valid && !out_ready, every output holds stable.
REQ-026 When out_ready && !in_valid, out_valid falls to 0 at the edge.
REQ-027 Write-back is independent of the handshake. When wb_en is set, R[wb_addr] = wb_data at the edge.
REQ-028 Bypass: a same-cycle capture whose read index equals wb_addr with wb_en set sees wb_data.
REQ-029 Bypass does not apply to r0 when R0_ZERO = 1.
REQ-030 Held outputs are not refreshed by later write-backs.
REQ-031 A wb_addr >= NREG is ignored, and a read of an index >= NREG returns 0.
REQ-032 Flush clears out_valid at the edge and blocks capture in the same cycle. Registers are unaffected, and a same-cycle write-back still occurs.

Reset
REQ-033 While reset_n = 0: all registers = 0, out_valid = 0, and every data output = 0.
REQ-034 Reset mid-operation discards any held instruction and any in-flight write.
REQ-035 in_ready = 1 on the first edge after release.

Structure
REQ-036 Package simple_pkg holds:
- the class encodings;
- the memwrite encodings;
- the sign-extension functions signext8 and signext4.
REQ-037 The register file is sub-module simple_regfile: 2 read ports, 1 write port, bypass, and the R0_ZERO behaviour.

Verification
REQ-038 Reset, then instr 16'hC1A0 (class 3, rs = 0, rt = 1, op 10) -> alu2 = 0, regaddress = 1, writereg = 1, and out_valid one cycle later.
REQ-039 wb R5 = 16'h0010, then a load with rt = 5 and imm8 = 8'hFC -> address = 16'h000C, memwrite = 01.
REQ-040 Same cycle: wb R3 = 16'h1234 and a store with rs = 3 captured -> storedata = 16'h1234 (bypass).
REQ-041 Hold out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0 and outputs unchanged. Release -> next instruction captured once, with no duplicate and no drop.
REQ-042 wb r0 = 16'hFFFF with R0_ZERO = 1, then read r0 -> 0. flush together with in_valid -> out_valid = 0 and the instruction is dropped.
REQ-043 Assert reset_n = 0 while out_valid = 1 -> all outputs 0 immediately. After release, the first read of any register returns 0.

Source files
------------

// File: rtl/simple_pkg.sv
// Shared encodings and helpers for the instruction decoder and register file.
package simple_pkg;

  // Instruction class, carried in instr[15:14]
  typedef enum logic [1:0] {
    CLS_LOAD  = 2'd0,
    CLS_STORE = 2'd1,
    CLS_LDI   = 2'd2,
    CLS_ALU   = 2'd3
  } instr_class_e;

  // Memory operation requested by the decoded instruction
  typedef enum logic [1:0] {
    MW_NONE  = 2'd0,
    MW_LOAD  = 2'd1,
    MW_STORE = 2'd2
  } memwrite_e;

  // Register index width is fixed by the ISA field
  localparam int unsigned REG_IDX_W = 3;

  // Sign-extension helpers produce this width; callers keep the low DATA_W bits
  localparam int unsigned EXT_W = 64;

  // ALU opcodes up to this value take R[rt] as the second operand, larger ones take instr[3:0]
  localparam logic [3:0] ALU_REG_OP_MAX = 4'd8;

  function automatic logic [EXT_W-1:0] signext8(input logic [7:0] v);
    return {{(EXT_W-8){v[7]}}, v};
  endfunction

  function automatic logic [EXT_W-1:0] signext4(input logic [3:0] v);
    return {{(EXT_W-4){v[3]}}, v};
  endfunction

endpackage

// File: rtl/simple_regfile.sv
// Register file: two combinational read ports with write-through bypass, one write port.
// With R0_ZERO set, r0 is hardwired to zero and never bypassed.
module simple_regfile
  import simple_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int R0_ZERO = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  input  logic [REG_IDX_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b
);

  localparam logic [REG_IDX_W:0] NREG_L = (REG_IDX_W+1)'(NREG);

  logic [DATA_W-1:0]    reg_vals [NREG];
  logic [REG_IDX_W-1:0] rd_addr  [2];
  logic [DATA_W-1:0]    rd_data  [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];

  // One storage register per index; write addresses beyond NREG match none of them
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    localparam logic [REG_IDX_W-1:0] IDX      = REG_IDX_W'(gi);
    localparam bit                   WRITABLE = !((R0_ZERO != 0) && (gi == 0));

    logic              wr_hit;
    logic [DATA_W-1:0] reg_q;
    logic [DATA_W-1:0] reg_d;

    assign wr_hit      = wr_en && (wr_addr == IDX) && WRITABLE;
    assign reg_d       = wr_hit ? wr_data : reg_q;
    assign reg_vals[gi] = reg_q;

    // Register storage, cleared by reset (which also drops any write in that cycle)
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end
  end

  // Read ports: out-of-range and hardwired-zero indices read 0, otherwise bypass a same-cycle write
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_comb begin
      rd_data[gi] = '0;
      if (({1'b0, rd_addr[gi]} < NREG_L) && !((R0_ZERO != 0) && (rd_addr[gi] == '0))) begin
        if (wr_en && (wr_addr == rd_addr[gi])) begin
          rd_data[gi] = wr_data;
        end else begin
          rd_data[gi] = reg_vals[rd_addr[gi]];
        end
      end
    end
  end

endmodule

// File: rtl/decode_regfile.sv
// Decode stage: reads operands from the register file, decodes the instruction by class
// and holds the result in an output register behind a valid/ready handshake.
module decode_regfile
  import simple_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NREG    = 8,
  parameter int R0_ZERO = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          instr,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    alu1,
  output logic [DATA_W-1:0]    alu2,
  output logic [3:0]           opcode,
  output logic                 writereg,
  output logic [1:0]           memwrite,
  output logic [REG_IDX_W-1:0] regaddress,
  output logic [DATA_W-1:0]    address,
  output logic [DATA_W-1:0]    storedata
);

  logic [REG_IDX_W-1:0] rs;
  logic [REG_IDX_W-1:0] rt;
  instr_class_e         cls;
  logic [EXT_W-1:0]     imm_ext;
  logic [DATA_W-1:0]    imm;
  logic [DATA_W-1:0]    r_rs;
  logic [DATA_W-1:0]    r_rt;
  logic                 capture;

  logic [DATA_W-1:0]    alu1_d, alu2_d, address_d, storedata_d;
  logic [3:0]           opcode_d;
  logic                 writereg_d;
  logic [1:0]           memwrite_d;
  logic [REG_IDX_W-1:0] regaddress_d;

  logic [DATA_W-1:0]    alu1_q, alu2_q, address_q, storedata_q;
  logic [3:0]           opcode_q;
  logic                 writereg_q;
  logic [1:0]           memwrite_q;
  logic [REG_IDX_W-1:0] regaddress_q;
  logic                 out_valid_q;

  assign rs      = instr[13:11];
  assign rt      = instr[10:8];
  assign cls     = instr_class_e'(instr[15:14]);
  assign imm_ext = signext8(instr[7:0]);
  assign imm     = imm_ext[DATA_W-1:0];

  // Upper extension bits are only present when DATA_W is narrower than the helper width
  if (DATA_W < EXT_W) begin : g_imm_unused
    logic imm_unused;
    assign imm_unused = ^imm_ext[EXT_W-1:DATA_W];
  end

  simple_regfile #(
    .DATA_W  (DATA_W),
    .NREG    (NREG),
    .R0_ZERO (R0_ZERO)
  ) u_regfile (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data),
    .rd_addr_a (rs),
    .rd_data_a (r_rs),
    .rd_addr_b (rt),
    .rd_data_b (r_rt)
  );

  // Ready whenever the output slot is empty or being drained this cycle; flush vetoes capture
  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Decode by instruction class; fields a class does not use stay zero
  always_comb begin
    alu1_d       = '0;
    alu2_d       = '0;
    address_d    = '0;
    storedata_d  = '0;
    opcode_d     = instr[7:4];
    writereg_d   = 1'b0;
    memwrite_d   = MW_NONE;
    regaddress_d = '0;
    unique case (cls)
      CLS_ALU: begin
        alu1_d       = r_rs;
        alu2_d       = (instr[7:4] <= ALU_REG_OP_MAX) ? r_rt : {{(DATA_W-4){1'b0}}, instr[3:0]};
        writereg_d   = 1'b1;
        regaddress_d = rt;
      end
      CLS_LOAD: begin
        alu1_d       = r_rs;
        alu2_d       = r_rt;
        address_d    = r_rt + imm;
        writereg_d   = 1'b1;
        memwrite_d   = MW_LOAD;
        regaddress_d = rs;
      end
      CLS_STORE: begin
        storedata_d = r_rs;
        address_d   = r_rt + imm;
        memwrite_d  = MW_STORE;
      end
      CLS_LDI: begin
        address_d    = imm;
        writereg_d   = 1'b1;
        memwrite_d   = MW_LOAD;
        regaddress_d = rt;
      end
      default: begin
        writereg_d = 1'b0;
      end
    endcase
  end

  // Output slot: load on capture, empty on flush or drain, otherwise hold everything
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      alu1_q       <= '0;
      alu2_q       <= '0;
      address_q    <= '0;
      storedata_q  <= '0;
      opcode_q     <= '0;
      writereg_q   <= 1'b0;
      memwrite_q   <= '0;
      regaddress_q <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (capture) begin
      out_valid_q  <= 1'b1;
      alu1_q       <= alu1_d;
      alu2_q       <= alu2_d;
      address_q    <= address_d;
      storedata_q  <= storedata_d;
      opcode_q     <= opcode_d;
      writereg_q   <= writereg_d;
      memwrite_q   <= memwrite_d;
      regaddress_q <= regaddress_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu1       = alu1_q;
  assign alu2       = alu2_q;
  assign address    = address_q;
  assign storedata  = storedata_q;
  assign opcode     = opcode_q;
  assign writereg   = writereg_q;
  assign memwrite   = memwrite_q;
  assign regaddress = regaddress_q;

endmodule

// File: tb/tb_decode_regfile.sv
// Testbench for decode_regfile: directed table, hand-written corner sequences and
// randomized traffic checked against a behavioural model of the decode stage.
module tb_decode_regfile;

  localparam int DW   = 16;
  localparam int NR   = 8;
  localparam int R0Z  = 1;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   instr;
  logic          wb_en;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu1, alu2, address, storedata;
  logic [3:0]    opcode;
  logic          writereg;
  logic [1:0]    memwrite;
  logic [2:0]    regaddress;

  decode_regfile #(.DATA_W(DW), .NREG(NR), .R0_ZERO(R0Z)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu1       (alu1),
    .alu2       (alu2),
    .opcode     (opcode),
    .writereg   (writereg),
    .memwrite   (memwrite),
    .regaddress (regaddress),
    .address    (address),
    .storedata  (storedata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] alu1;
    logic [15:0] alu2;
    logic [3:0]  op;
    logic        wr;
    logic [1:0]  mw;
    logic [2:0]  ra;
    logic [15:0] addr;
    logic [15:0] sd;
  } outs_t;

  typedef struct {
    logic [15:0] instr;
    outs_t       exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [15:0] mregs [NR];
  logic        m_valid;
  outs_t       m_out;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register read as the architecture defines it, including same-cycle write-back visibility
  function automatic logic [15:0] m_rd(input logic [2:0] idx);
    if (int'(idx) >= NR) return 16'h0;
    if (R0Z != 0 && idx == 3'd0) return 16'h0;
    if (wb_en && wb_addr == idx) return wb_data;
    return mregs[idx];
  endfunction

  function automatic outs_t m_decode(input logic [15:0] ins);
    outs_t o;
    logic [15:0] simm;
    logic [2:0] s, t;
    o = '0;
    s = ins[13:11];
    t = ins[10:8];
    simm = {{8{ins[7]}}, ins[7:0]};
    o.op = ins[7:4];
    case (ins[15:14])
      2'd3: begin
        o.alu1 = m_rd(s);
        o.alu2 = (ins[7:4] <= 4'd8) ? m_rd(t) : {12'h0, ins[3:0]};
        o.wr = 1'b1; o.ra = t;
      end
      2'd0: begin
        o.alu1 = m_rd(s); o.alu2 = m_rd(t);
        o.addr = m_rd(t) + simm;
        o.wr = 1'b1; o.mw = 2'b01; o.ra = s;
      end
      2'd1: begin
        o.sd = m_rd(s); o.addr = m_rd(t) + simm;
        o.mw = 2'b10;
      end
      default: begin
        o.addr = simm; o.wr = 1'b1; o.mw = 2'b01; o.ra = t;
      end
    endcase
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = 16'h0;
    m_valid = 1'b0;
    m_out = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, {15'h0, out_valid}, 16'h0);
    chk({tag, "_alu1"}, alu1, 16'h0);
    chk({tag, "_alu2"}, alu2, 16'h0);
    chk({tag, "_opcode"}, {12'h0, opcode}, 16'h0);
    chk({tag, "_writereg"}, {15'h0, writereg}, 16'h0);
    chk({tag, "_memwrite"}, {14'h0, memwrite}, 16'h0);
    chk({tag, "_regaddress"}, {13'h0, regaddress}, 16'h0);
    chk({tag, "_address"}, address, 16'h0);
    chk({tag, "_storedata"}, storedata, 16'h0);
  endtask

  task automatic chk_outs(input string tag, input outs_t e);
    chk({tag, "_alu1"}, alu1, e.alu1);
    chk({tag, "_alu2"}, alu2, e.alu2);
    chk({tag, "_opcode"}, {12'h0, opcode}, {12'h0, e.op});
    chk({tag, "_writereg"}, {15'h0, writereg}, {15'h0, e.wr});
    chk({tag, "_memwrite"}, {14'h0, memwrite}, {14'h0, e.mw});
    chk({tag, "_regaddress"}, {13'h0, regaddress}, {13'h0, e.ra});
    chk({tag, "_address"}, address, e.addr);
    chk({tag, "_storedata"}, storedata, e.sd);
  endtask

  // One clock cycle with inputs already driven: checks in_ready before the edge,
  // advances the model at the edge, then checks valid and held outputs after it.
  task automatic cycle();
    logic rdy;
    #1;
    rdy = !m_valid || out_ready;
    chk("in_ready", {15'h0, in_ready}, {15'h0, rdy});
    @(posedge clock);
    if (in_valid && rdy && !flush) begin
      m_out = m_decode(instr);
      m_valid = 1'b1;
    end else if (flush || out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && int'(wb_addr) < NR && !(R0Z != 0 && wb_addr == 3'd0)) mregs[wb_addr] = wb_data;
    #1;
    chk("out_valid", {15'h0, out_valid}, {15'h0, m_valid});
    if (m_valid) chk_outs("model", m_out);
    $display("cyc t=%0t instr=%h iv=%0d or=%0d fl=%0d wb=%0d/%0d/%h -> ov=%0d a1=%h a2=%h adr=%h sd=%h",
             $time, instr, in_valid, out_ready, flush, wb_en, wb_addr, wb_data,
             out_valid, alu1, alu2, address, storedata);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0; instr = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: registers preloaded with Ri = 16'h1111*i before these are applied
    vecs[0] = '{16'hC1A0, '{16'h0000, 16'h0000, 4'hA, 1'b1, 2'b00, 3'd1, 16'h0000, 16'h0000}};
    vecs[1] = '{16'hD330, '{16'h2222, 16'h3333, 4'h3, 1'b1, 2'b00, 3'd3, 16'h0000, 16'h0000}};
    vecs[2] = '{16'hE58F, '{16'h4444, 16'h5555, 4'h8, 1'b1, 2'b00, 3'd5, 16'h0000, 16'h0000}};
    vecs[3] = '{16'hE597, '{16'h4444, 16'h0007, 4'h9, 1'b1, 2'b00, 3'd5, 16'h0000, 16'h0000}};
    vecs[4] = '{16'h3705, '{16'h6666, 16'h7777, 4'h0, 1'b1, 2'b01, 3'd6, 16'h777C, 16'h0000}};
    vecs[5] = '{16'h0A80, '{16'h1111, 16'h2222, 4'h8, 1'b1, 2'b01, 3'd1, 16'h21A2, 16'h0000}};
    vecs[6] = '{16'h5CFF, '{16'h0000, 16'h0000, 4'hF, 1'b0, 2'b10, 3'd0, 16'h4443, 16'h3333}};
    vecs[7] = '{16'h8E7F, '{16'h0000, 16'h0000, 4'h7, 1'b1, 2'b01, 3'd6, 16'h007F, 16'h0000}};
    vecs[8] = '{16'h829C, '{16'h0000, 16'h0000, 4'h9, 1'b1, 2'b01, 3'd2, 16'hFF9C, 16'h0000}};
    vecs[9] = '{16'h4101, '{16'h0000, 16'h0000, 4'h0, 1'b0, 2'b10, 3'd0, 16'h1112, 16'h0000}};

    // Reset state
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    // First instruction after reset: one-cycle latency, imm-operand ALU op
    instr = 16'hC1A0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("first_pre_valid", {15'h0, out_valid}, 16'h0);
    cycle();
    chk("first_alu2", alu2, 16'h0000);
    chk("first_regaddress", {13'h0, regaddress}, 16'd1);
    chk("first_writereg", {15'h0, writereg}, 16'd1);
    chk("first_valid", {15'h0, out_valid}, 16'd1);
    in_valid = 1'b0;

    // Preload registers
    for (int i = 1; i < 8; i++) begin
      wb_en = 1'b1; wb_addr = 3'(i); wb_data = 16'(16'h1111 * i);
      cycle();
    end
    wb_en = 1'b0;

    // Directed table
    for (int v = 0; v < 10; v++) begin
      instr = vecs[v].instr; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      chk_outs($sformatf("vec%0d", v), vecs[v].exp);
    end
    in_valid = 1'b0;
    cycle();

    // Write-back then load with negative offset
    wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h0010;
    cycle();
    wb_en = 1'b0; instr = 16'h05FC; in_valid = 1'b1;
    cycle();
    chk("ld_address", address, 16'h000C);
    chk("ld_memwrite", {14'h0, memwrite}, 16'h0001);
    in_valid = 1'b0;

    // Same-cycle write-back is bypassed into a store capture
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234; instr = 16'h5800; in_valid = 1'b1;
    cycle();
    chk("byp_storedata", storedata, 16'h1234);
    wb_en = 1'b0; in_valid = 1'b0;
    cycle();

    // Backpressure: hold three cycles, then the waiting instruction goes through exactly once
    instr = 16'hD330; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0; instr = 16'hE597;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_in_ready", {15'h0, in_ready}, 16'h0);
      chk("bp_alu1_hold", alu1, 16'h2222);
      chk("bp_opcode_hold", {12'h0, opcode}, 16'h0003);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next_opcode", {12'h0, opcode}, 16'h0009);
    chk("bp_next_alu2", alu2, 16'h0007);
    in_valid = 1'b0;
    cycle();
    chk("bp_no_dup", {15'h0, out_valid}, 16'h0);

    // r0 stays zero, including against a same-cycle write-back
    wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF; instr = 16'hC000; in_valid = 1'b1;
    cycle();
    chk("r0_bypass_alu1", alu1, 16'h0000);
    wb_en = 1'b0;
    cycle();
    chk("r0_read_alu1", alu1, 16'h0000);
    chk("r0_read_alu2", alu2, 16'h0000);

    // Flush with a valid input drops both the held and the offered instruction
    flush = 1'b1; instr = 16'h8E7F; in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    chk("flush_valid", {15'h0, out_valid}, 16'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("flush_dropped", {15'h0, out_valid}, 16'h0);

    // Reset while an instruction is held and a write is in flight
    instr = 16'h3705; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'hABCD;
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(posedge clock);
    #1;
    idle_inputs();
    reset_n = 1'b1;
    for (int i = 1; i < 8; i++) begin
      instr = {2'b11, 3'(i), 3'(i), 8'h00}; in_valid = 1'b1;
      cycle();
      chk($sformatf("postrst_r%0d_a", i), alu1, 16'h0000);
      chk($sformatf("postrst_r%0d_b", i), alu2, 16'h0000);
    end
    in_valid = 1'b0;
    cycle();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 11) == 0);
      wb_en     = 1'($urandom_range(0, 1));
      wb_addr   = 3'($urandom_range(0, 7));
      wb_data   = 16'($urandom);
      instr     = 16'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
